// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the K=7, rate-1/2 Viterbi decoder.
package viterbi_pkg;

  localparam int unsigned K          = 7;
  localparam int unsigned S_W        = K - 1;
  localparam int unsigned NUM_STATES = 1 << S_W;
  localparam int unsigned PM_W       = 8;
  localparam int unsigned INIT_PM    = 64;
  localparam int unsigned BM_W       = 2;
  localparam int unsigned LVLS       = S_W;

  typedef logic [PM_W-1:0] pm_t;
  typedef logic [S_W-1:0]  state_t;
  typedef logic [BM_W-1:0] bm_t;

  // Predecessor of state s when the shifted-out bit was b.
  function automatic state_t prev_state(input state_t s, input logic b);
    return {s[S_W-2:0], b};
  endfunction

  function automatic pm_t reset_pm(input int unsigned s);
    return (s == 0) ? '0 : PM_W'(INIT_PM);
  endfunction

endpackage

// File: rtl/acs_cell.sv
// Combinational add/saturate/compare/select for one trellis state.
module acs_cell
  import viterbi_pkg::*;
(
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [BM_W-1:0] bm0,
  input  logic [BM_W-1:0] bm1,
  output logic [PM_W-1:0] new_pm,
  output logic            dec
);

  localparam int unsigned SUM_W = PM_W + 1;

  logic [SUM_W-1:0] sum0;
  logic [SUM_W-1:0] sum1;
  pm_t              cand0;
  pm_t              cand1;

  // Ties keep p0, so p1 wins only on a strictly smaller candidate.
  always_comb begin
    sum0   = {1'b0, pm0} + SUM_W'(bm0);
    sum1   = {1'b0, pm1} + SUM_W'(bm1);
    cand0  = sum0[PM_W] ? '1 : sum0[PM_W-1:0];
    cand1  = sum1[PM_W] ? '1 : sum1[PM_W-1:0];
    dec    = (cand1 < cand0);
    new_pm = dec ? cand1 : cand0;
  end

endmodule

// File: rtl/acs_array.sv
// Add-compare-select array: updates all 64 path metrics per symbol, emits survivor
// bits, normalises metrics and reports the minimum-metric state one cycle later.
module acs_array
  import viterbi_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    bm_valid,
  input  logic [NUM_STATES*4-1:0] bm_bus,
  output logic                    dec_valid,
  output logic [NUM_STATES-1:0]   dec_bits,
  output logic                    best_valid,
  output logic [K-2:0]            best_state,
  output logic [PM_W-1:0]         best_pm,
  output logic                    pm_norm
);

  pm_t                   pm      [NUM_STATES];
  pm_t                   acs_pm  [NUM_STATES];
  pm_t                   norm_pm [NUM_STATES];
  logic [NUM_STATES-1:0] acs_dec;
  logic [NUM_STATES-1:0] acs_msb;
  logic                  all_msb;

  pm_t                   tv [LVLS+1][NUM_STATES];
  state_t                ti [LVLS+1][NUM_STATES];
  pm_t                   min_pm;
  state_t                min_idx;

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_cell
    localparam state_t P0 = prev_state(state_t'(s), 1'b0);
    localparam state_t P1 = prev_state(state_t'(s), 1'b1);

    acs_cell u_cell (
      .pm0    (pm[P0]),
      .pm1    (pm[P1]),
      .bm0    (bm_bus[4*s +: BM_W]),
      .bm1    (bm_bus[4*s+2 +: BM_W]),
      .new_pm (acs_pm[s]),
      .dec    (acs_dec[s])
    );

    assign acs_msb[s] = acs_pm[s][PM_W-1];
  end

  // Once every metric is in the upper half, subtracting 128 preserves all differences.
  always_comb begin
    all_msb = &acs_msb;
    for (int i = 0; i < NUM_STATES; i++) begin
      norm_pm[i] = all_msb ? {1'b0, acs_pm[i][PM_W-2:0]} : acs_pm[i];
    end
  end

  // Pairwise minimum tree; the right operand wins only when strictly smaller.
  always_comb begin
    for (int l = 0; l <= LVLS; l++) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        tv[l][i] = '0;
        ti[l][i] = '0;
      end
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      tv[0][i] = pm[i];
      ti[0][i] = state_t'(i);
    end
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < NUM_STATES / 2; i++) begin
        if (i < (NUM_STATES >> (l + 1))) begin
          if (tv[l][2*i+1] < tv[l][2*i]) begin
            tv[l+1][i] = tv[l][2*i+1];
            ti[l+1][i] = ti[l][2*i+1];
          end else begin
            tv[l+1][i] = tv[l][2*i];
            ti[l+1][i] = ti[l][2*i];
          end
        end
      end
    end
    min_pm  = tv[LVLS][0];
    min_idx = ti[LVLS][0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STATES; i++) pm[i] <= reset_pm(i);
      dec_valid  <= 1'b0;
      dec_bits   <= '0;
      pm_norm    <= 1'b0;
      best_valid <= 1'b0;
      best_state <= '0;
      best_pm    <= '0;
    end else begin
      if (frame_start) begin
        for (int i = 0; i < NUM_STATES; i++) pm[i] <= reset_pm(i);
        dec_valid <= 1'b0;
        pm_norm   <= 1'b0;
      end else if (bm_valid) begin
        for (int i = 0; i < NUM_STATES; i++) pm[i] <= norm_pm[i];
        dec_bits  <= acs_dec;
        dec_valid <= 1'b1;
        pm_norm   <= all_msb;
      end else begin
        dec_valid <= 1'b0;
        pm_norm   <= 1'b0;
      end
      // pm already holds the metrics reported with dec_valid, so the search trails by one.
      best_valid <= dec_valid;
      if (dec_valid) begin
        best_state <= min_idx;
        best_pm    <= min_pm;
      end
    end
  end

endmodule

// File: tb/tb_acs_array.sv
// Directed and random checks of acs_array against a cycle-level reference model.
module tb_acs_array;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_start;
  logic         bm_valid;
  logic [255:0] bm_bus;
  logic         dec_valid;
  logic [63:0]  dec_bits;
  logic         best_valid;
  logic [5:0]   best_state;
  logic [7:0]   best_pm;
  logic         pm_norm;

  int total = 0;
  int bad   = 0;

  int          mpm [64];
  logic        e_dv;
  logic [63:0] e_db;
  logic        e_norm;
  logic        e_bv;
  logic [5:0]  e_bs;
  logic [7:0]  e_bp;

  acs_array dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .bm_valid    (bm_valid),
    .bm_bus      (bm_bus),
    .dec_valid   (dec_valid),
    .dec_bits    (dec_bits),
    .best_valid  (best_valid),
    .best_state  (best_state),
    .best_pm     (best_pm),
    .pm_norm     (pm_norm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] uniform_bm(input logic [1:0] v);
    logic [255:0] r;
    for (int i = 0; i < 128; i++) r[2*i +: 2] = v;
    return r;
  endfunction

  function automatic logic [255:0] random_bm();
    logic [255:0] r;
    for (int i = 0; i < 128; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mpm[i] = (i == 0) ? 0 : 64;
    e_dv = 1'b0; e_db = '0; e_norm = 1'b0;
    e_bv = 1'b0; e_bs = '0; e_bp = '0;
  endtask

  task automatic model_step(input logic fs, input logic bv, input logic [255:0] bm);
    int np [64];
    int c0, c1, p0, mv, mi;
    logic all_hi;
    e_bv = e_dv;
    if (e_dv) begin
      mv = mpm[0]; mi = 0;
      for (int i = 1; i < 64; i++) if (mpm[i] < mv) begin mv = mpm[i]; mi = i; end
      e_bs = 6'(mi);
      e_bp = 8'(mv);
    end
    if (fs) begin
      for (int i = 0; i < 64; i++) mpm[i] = (i == 0) ? 0 : 64;
      e_dv = 1'b0; e_norm = 1'b0;
    end else if (bv) begin
      all_hi = 1'b1;
      for (int s = 0; s < 64; s++) begin
        p0 = (s * 2) % 64;
        c0 = mpm[p0] + int'(bm[4*s +: 2]);
        c1 = mpm[p0 + 1] + int'(bm[4*s+2 +: 2]);
        if (c0 > 255) c0 = 255;
        if (c1 > 255) c1 = 255;
        if (c1 < c0) begin np[s] = c1; e_db[s] = 1'b1; end
        else begin np[s] = c0; e_db[s] = 1'b0; end
        if (np[s] < 128) all_hi = 1'b0;
      end
      for (int s = 0; s < 64; s++) mpm[s] = all_hi ? np[s] - 128 : np[s];
      e_dv = 1'b1; e_norm = all_hi;
    end else begin
      e_dv = 1'b0; e_norm = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [511:0] obs, exp;
    for (int i = 0; i < 64; i++) begin
      obs[8*i +: 8] = dut.pm[i];
      exp[8*i +: 8] = 8'(mpm[i]);
    end
    chk({tag, ".dec_valid"},  512'(dec_valid),  512'(e_dv));
    chk({tag, ".dec_bits"},   512'(dec_bits),   512'(e_db));
    chk({tag, ".pm_norm"},    512'(pm_norm),    512'(e_norm));
    chk({tag, ".best_valid"}, 512'(best_valid), 512'(e_bv));
    chk({tag, ".best_state"}, 512'(best_state), 512'(e_bs));
    chk({tag, ".best_pm"},    512'(best_pm),    512'(e_bp));
    chk({tag, ".pm"},         obs,              exp);
  endtask

  task automatic step(input string tag, input logic fs, input logic bv, input logic [255:0] bm);
    frame_start = fs;
    bm_valid    = bv;
    bm_bus      = bm;
    @(posedge clk);
    #1;
    model_step(fs, bv, bm);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    frame_start = 1'b0;
    bm_valid    = 1'b1;
    bm_bus      = uniform_bm(2'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    bm_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [255:0] bm;
    logic         seen;
    logic         all_low;

    // 1: reset then idle
    do_reset();
    chk("rst.dec_valid", 512'(dec_valid), 512'(0));
    chk("rst.pm0", 512'(dut.pm[0]), 512'(0));
    chk("rst.pm63", 512'(dut.pm[63]), 512'(64));
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 1'b0, '0);

    // 2: single all-zero symbol
    step("zero1", 1'b0, 1'b1, '0);
    chk("zero1.dv_lit", 512'(dec_valid), 512'(1));
    chk("zero1.db_lit", 512'(dec_bits), 512'(0));
    chk("zero1.pm32", 512'(dut.pm[32]), 512'(0));
    chk("zero1.pm1", 512'(dut.pm[1]), 512'(64));
    step("zero1b", 1'b0, 1'b0, '0);
    chk("zero1b.bv_lit", 512'(best_valid), 512'(1));
    chk("zero1b.bs_lit", 512'(best_state), 512'(0));
    chk("zero1b.bp_lit", 512'(best_pm), 512'(0));

    // 3: flatten to 0, raise to 18, then shape pm[10]=20 / pm[11]=18
    for (int i = 0; i < 5; i++) step("flat0", 1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) step("flat3", 1'b0, 1'b1, uniform_bm(2'd3));
    bm = '0;
    bm[40 +: 4] = 4'b1010;
    step("shapeA", 1'b0, 1'b1, bm);
    chk("shapeA.pm10", 512'(dut.pm[10]), 512'(20));
    chk("shapeA.pm11", 512'(dut.pm[11]), 512'(18));
    bm[22 +: 2] = 2'd2;
    step("tie", 1'b0, 1'b1, bm);
    chk("tie.dec5", 512'(dec_bits[5]), 512'(0));
    chk("tie.pm5", 512'(dut.pm[5]), 512'(20));
    bm[22 +: 2] = 2'd1;
    step("p1win", 1'b0, 1'b1, bm);
    chk("p1win.dec5", 512'(dec_bits[5]), 512'(1));
    chk("p1win.pm5", 512'(dut.pm[5]), 512'(19));

    // 4: climb with bm=2 until normalisation
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step("climb", 1'b0, 1'b1, uniform_bm(2'd2));
      if (e_norm) begin
        seen = 1'b1;
        chk("climb.norm_lit", 512'(pm_norm), 512'(1));
        all_low = 1'b1;
        for (int s = 0; s < 64; s++) if (dut.pm[s] >= 8'd128) all_low = 1'b0;
        chk("climb.all_below_128", 512'(all_low), 512'(1));
      end
    end
    chk("climb.norm_seen", 512'(seen), 512'(1));

    // 5: frame_start coincident with bm_valid
    step("pre_fs", 1'b0, 1'b1, uniform_bm(2'd1));
    step("fs", 1'b1, 1'b1, uniform_bm(2'd1));
    chk("fs.dv_lit", 512'(dec_valid), 512'(0));
    chk("fs.bv_inflight", 512'(best_valid), 512'(1));
    chk("fs.pm0", 512'(dut.pm[0]), 512'(0));
    chk("fs.pm5", 512'(dut.pm[5]), 512'(64));
    step("post_fs", 1'b0, 1'b1, random_bm());
    step("post_fs2", 1'b0, 1'b0, '0);

    // mid-stream reset drops in-flight pulses
    step("pre_rst", 1'b0, 1'b1, random_bm());
    do_reset();
    step("post_rst", 1'b0, 1'b0, '0);
    step("post_rst2", 1'b0, 1'b0, '0);
    chk("post_rst.bv_lit", 512'(best_valid), 512'(0));

    // 6: random stream with gaps
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) step("rnd_gap", 1'b0, 1'b0, random_bm());
      step("rnd", 1'b0, 1'b1, random_bm());
    end
    step("tail", 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
